// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/[parity]/stop receiver feeding a one-entry valid/ready holding register (parity via SERIAL_FRAME_RX_PARITY_EN).
// Latency start->valid N+1 edges (N+2 with parity); a good word that finds the register full and not draining is dropped with overrun_o.
module serial_frame_rx #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         serial_i,
    output logic [N-1:0] parallel_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         frame_err_o,
    output logic         parity_err_o,
    output logic         overrun_o
);
    localparam int CW = $clog2(N + 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, STOP, BREAK} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shreg;
    logic          stop_good;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_bad;
    assign stop_good = serial_i && !par_bad;
`else
    assign stop_good    = serial_i;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            parallel_o  <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!serial_i) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting right leaves it at bit 0
                    shreg <= {serial_i, shreg[N-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    par_bad <= ^{serial_i, shreg};
                    state   <= STOP;
                end
`endif
                STOP: begin
                    if (stop_good) begin
                        // a same-edge accept frees the slot for the new word
                        if (!valid_o || ready_i) begin
                            parallel_o <= shreg;
                            valid_o    <= 1'b1;
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end
                    if (!serial_i) begin
                        frame_err_o <= 1'b1;
                    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    parity_err_o <= par_bad;
`endif
                    state <= serial_i ? IDLE : BREAK;
                end
                BREAK: begin
                    if (serial_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed vector table plus randomized frame stream against a frame-level model.
`timescale 1ns/1ps
module tb_serial_frame_rx;
    localparam int N = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam logic lo = 1'b0;
    localparam logic hi = 1'b1;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         serial_i;
    logic         ready_i;
    logic [N-1:0] parallel_o;
    logic         valid_o;
    logic         frame_err_o;
    logic         parity_err_o;
    logic         overrun_o;

    int vectors     = 0;
    int miscompares = 0;

    serial_frame_rx #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .serial_i    (serial_i),
        .parallel_o  (parallel_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rst;
        logic         ser;
        logic         rdy;
        logic         vld;
        logic [N-1:0] dat;
        logic         fe;
        logic         pe;
        logic         ov;
    } vec_t;
    vec_t tbl[$];

    // random stream: line level, event per cycle ({pe, fe, good}), word delivered at the stop
    logic         line_q[$];
    logic [2:0]   ev_q[$];
    logic [N-1:0] wd_q[$];

    task automatic add(input logic r, input logic s, input logic y, input logic v,
                       input logic [N-1:0] d, input logic fe, input logic pe, input logic ov);
        vec_t e;
        e.rst = r; e.ser = s; e.rdy = y; e.vld = v; e.dat = d; e.fe = fe; e.pe = pe; e.ov = ov;
        tbl.push_back(e);
    endtask

    task automatic idle(input int n, input logic v, input logic [N-1:0] d);
        for (int i = 0; i < n; i++) add(hi, hi, lo, v, d, lo, lo, lo);
    endtask

    task automatic frame(input logic [N-1:0] w, input logic stop, input logic flip, input logic rdy_stop,
                         input logic v0, input logic [N-1:0] d0, input logic v1, input logic [N-1:0] d1,
                         input logic fe, input logic pe, input logic ov);
        add(hi, lo, lo, v0, d0, lo, lo, lo);
        for (int i = 0; i < N; i++) add(hi, w[i], lo, v0, d0, lo, lo, lo);
        if (P == 1) add(hi, ^w ^ flip, lo, v0, d0, lo, lo, lo);
        add(hi, stop, rdy_stop, v1, d1, fe, pe, ov);
    endtask

    task automatic push(input logic s, input logic [2:0] ev, input logic [N-1:0] w);
        line_q.push_back(s);
        ev_q.push_back(ev);
        wd_q.push_back(w);
    endtask

    task automatic apply(input logic r, input logic s, input logic y, input logic [N+3:0] exp,
                         input string tag, input int idx);
        rst_i    = r;
        serial_i = s;
        ready_i  = y;
        @(posedge clk_i);
        #1;
        vectors++;
        if ({valid_o, parallel_o, frame_err_o, parity_err_o, overrun_o} !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got vld=%b dat=%h fe=%b pe=%b ov=%b, expected vld=%b dat=%h fe=%b pe=%b ov=%b",
                     tag, idx, valid_o, parallel_o, frame_err_o, parity_err_o, overrun_o,
                     exp[N+3], exp[N+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin : main
        logic [N-1:0] w;
        logic         bs;
        logic         bp;
        logic         prev_bad;
        logic         y;
        logic         fe;
        logic         pe;
        logic         ov;
        logic         m_vld;
        logic [N-1:0] m_dat;
        int           gap;

        rst_i    = 1'b0;
        serial_i = 1'b1;
        ready_i  = 1'b0;

        // reset and idle
        for (int i = 0; i < 3; i++) add(lo, hi, lo, lo, '0, lo, lo, lo);
        idle(20, lo, '0);
        // single good frame, held, then accepted
        frame(8'hA5, hi, lo, lo, lo, '0, hi, 8'hA5, lo, lo, lo);
        idle(3, hi, 8'hA5);
        add(hi, hi, hi, lo, 8'hA5, lo, lo, lo);
        idle(2, lo, 8'hA5);
        // framing error, line held low in BREAK, then recovery
        frame(8'h3C, lo, lo, lo, lo, 8'hA5, lo, 8'hA5, hi, lo, lo);
        for (int i = 0; i < 5; i++) add(hi, lo, lo, lo, 8'hA5, lo, lo, lo);
        add(hi, hi, lo, lo, 8'hA5, lo, lo, lo);
        frame(8'h81, hi, lo, lo, lo, 8'hA5, hi, 8'h81, lo, lo, lo);
        add(hi, hi, hi, lo, 8'h81, lo, lo, lo);
        // overrun, then same-edge accept and reload
        frame(8'h11, hi, lo, lo, lo, 8'h81, hi, 8'h11, lo, lo, lo);
        frame(8'h22, hi, lo, lo, hi, 8'h11, hi, 8'h11, lo, lo, hi);
        add(hi, hi, hi, lo, 8'h11, lo, lo, lo);
        frame(8'h11, hi, lo, lo, lo, 8'h11, hi, 8'h11, lo, lo, lo);
        frame(8'h22, hi, lo, hi, hi, 8'h11, hi, 8'h22, lo, lo, lo);
        add(hi, hi, hi, lo, 8'h22, lo, lo, lo);
        // reset after data bit 4 of 8'hFF
        add(hi, lo, lo, lo, 8'h22, lo, lo, lo);
        for (int i = 0; i < 4; i++) add(hi, hi, lo, lo, 8'h22, lo, lo, lo);
        add(lo, hi, lo, lo, '0, lo, lo, lo);
        idle(1, lo, '0);
        frame(8'h0F, hi, lo, lo, lo, '0, hi, 8'h0F, lo, lo, lo);
        add(hi, hi, hi, lo, 8'h0F, lo, lo, lo);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        frame(8'h07, hi, lo, lo, lo, 8'h0F, hi, 8'h07, lo, lo, lo);
        add(hi, hi, hi, lo, 8'h07, lo, lo, lo);
        frame(8'h07, hi, hi, lo, lo, 8'h07, lo, 8'h07, lo, hi, lo);
        idle(1, lo, 8'h07);
        frame(8'h33, lo, hi, lo, lo, 8'h07, lo, 8'h07, hi, hi, lo);
        idle(2, lo, 8'h07);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].ser, tbl[i].rdy,
                  {tbl[i].vld, tbl[i].dat, tbl[i].fe, tbl[i].pe, tbl[i].ov}, "dir", i);
        end

        // randomized frame stream
        prev_bad = 1'b0;
        for (int f = 0; f < 60; f++) begin
            gap = int'($urandom_range(0, 3));
            if (prev_bad && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) push(hi, 3'b000, '0);
            w  = N'($urandom);
            bs = ($urandom_range(0, 6) == 0);
            bp = (P == 1) && ($urandom_range(0, 4) == 0);
            push(lo, 3'b000, '0);
            for (int i = 0; i < N; i++) push(w[i], 3'b000, '0);
            if (P == 1) push(^w ^ bp, 3'b000, '0);
            push(!bs, {bp, bs, !bs && !bp}, w);
            prev_bad = bs;
        end
        for (int i = 0; i < 3; i++) push(hi, 3'b000, '0);

        apply(lo, hi, lo, '0, "rand_rst", 0);
        m_vld = 1'b0;
        m_dat = '0;
        for (int c = 0; c < line_q.size(); c++) begin
            y  = 1'($urandom_range(0, 1));
            fe = ev_q[c][1];
            pe = ev_q[c][2];
            ov = 1'b0;
            if (ev_q[c][0]) begin
                if (!m_vld || y) begin
                    m_dat = wd_q[c];
                    m_vld = 1'b1;
                end else begin
                    ov = 1'b1;
                end
            end else if (m_vld && y) begin
                m_vld = 1'b0;
            end
            apply(hi, line_q[c], y, {m_vld, m_dat, fe, pe, ov}, "rand", c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver: the receive end of the serial link whose transmit end is the PISO-based framer. It samples `serial_i` once per clock and detects a start bit. It then shifts in `N` data bits LSB-first, optionally checks even parity, and checks the stop bit. Each good word goes into a one-entry holding register presented on a valid/ready handshake. It sits between the serial pin logic and any parallel consumer, replacing a bare SIPO where framing and flow control are needed.

## Interface
- `N`, default 8: data bits per frame (≥2).
- `clk_i`, in, 1: clock; every transition of the block happens on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `serial_i`, in, 1: serial line. Idles high; must be synchronous to `clk_i`.
- `parallel_o`, out, N: received word, valid while `valid_o` = 1.
- `valid_o`, out, 1: holding register full.
- `ready_i`, in, 1: consumer accepts the word on an edge where `valid_o` = `ready_i` = 1.
- `frame_err_o`, out, 1: one-cycle pulse, stop bit sampled 0.
- `parity_err_o`, out, 1: one-cycle pulse, parity mismatch; constant 0 when parity is compiled out.
- `overrun_o`, out, 1: one-cycle pulse, a completed good word was dropped.

## Operation
- States: IDLE, DATA, PARITY (present only with the macro), STOP, BREAK.
- IDLE:
  - `serial_i` = 0 sampled → DATA, bit counter cleared.
  - `serial_i` = 1 → stay in IDLE.
- DATA:
  - Each edge shifts `serial_i` into the MSB of the shift register and shifts the register right, so the first data bit ends at bit 0.
  - After the N-th bit → PARITY if present, else STOP.
  - Bit counter width is $clog2(N+1).
- PARITY: sample the parity bit and compute the error flag (even parity over the data plus parity bit) → STOP.
- STOP, with `serial_i` = 1 and no parity error:
  - The word is "completed good".
  - If the holding register is empty, or is being accepted on this same edge, load it: `parallel_o` ← shift register, `valid_o` = 1.
  - Otherwise drop the new word, keep the old one, and pulse `overrun_o`.
  - Next state: IDLE.
- STOP, with `serial_i` = 0:
  - Pulse `frame_err_o` and discard the word.
  - Next state: BREAK.
- STOP, with a parity error: pulse `parity_err_o` and discard the word.
  - Both error pulses may fire together.
  - If the stop bit is 1 → IDLE; if it is 0 → BREAK.
- BREAK: wait for `serial_i` = 1 → IDLE. A 0 in BREAK is never treated as a start bit.
- Handshake:
  - `valid_o` falls on the edge that samples `ready_i` = 1, unless a good word completes on that same edge; then `valid_o` stays 1 with the new word.
  - `parallel_o` is stable while `valid_o` = 1 and no accept occurs.
  - `ready_i` while `valid_o` = 0 is ignored.
- Discarded and dropped words never change `parallel_o`.

## Timing
- Reset (`rst_i` = 0, any time, including mid-frame): state IDLE, shift register and counter 0, `parallel_o` = 0, and `valid_o`, `frame_err_o`, `parity_err_o`, `overrun_o` all 0. A partial frame is lost.
- Start bit sampled at edge k:
  - Data at edges k+1..k+N.
  - Parity (if present) at k+N+1.
  - Stop at k+N+1, or k+N+2 with parity.
  - `valid_o` is 1 after the stop edge.
  - Latency start→valid is N+1 edges, or N+2 with parity.
- Back-to-back: the next start bit may be sampled on the edge right after the stop edge. Minimum frame period is N+2 cycles, or N+3 with parity.
- Error and overrun pulses are registered: high for exactly the cycle after the stop edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_FRAME_RX_PARITY_EN`:
  - Defined: PARITY state present; an even parity bit follows the data bits; `parity_err_o` is live.
  - Undefined: no parity bit; stop follows data directly; `parity_err_o` tied 0.

## Test plan
- Reset and idle:
  - Hold `rst_i` = 0 for 3 cycles with `serial_i` = 1 → all outputs 0.
  - Release, then 20 idle-high cycles → `valid_o` stays 0.
- Single good frame and handshake:
  - Stimulus (N=8, no parity): bits 0,1,0,1,0,0,1,0,1,1 on successive edges, `ready_i` = 0.
  - Response: `valid_o` = 1 and `parallel_o` = 8'hA5 after edge 10, held.
  - Raise `ready_i` for 1 cycle → `valid_o` = 0.
- Framing error and BREAK:
  - Frame for 8'h3C with stop = 0, then `serial_i` = 0 for 5 more cycles.
  - Response: `frame_err_o` pulses once, no `valid_o`, no new frame starts.
  - Then 1 then a 8'h81 frame → `parallel_o` = 8'h81.
- Overrun and simultaneous accept:
  - Back-to-back frames 8'h11, 8'h22 with `ready_i` = 0 → `overrun_o` pulses, `parallel_o` stays 8'h11.
  - Repeat with `ready_i` = 1 on the second stop edge → `parallel_o` = 8'h22, `valid_o` stays 1, no overrun.
- Reset mid-frame: drop `rst_i` after data bit 4 of 8'hFF → outputs 0; the next full 8'h0F frame is received correctly.
- With `SERIAL_FRAME_RX_PARITY_EN`:
  - 8'h07 with parity bit 1 → valid, 8'h07.
  - 8'h07 with parity bit 0 → `parity_err_o` pulse, no `valid_o`.
